// File: rtl/game_phase_ctrl.sv
// Round-level sequencer for Sky-Stacker: get-ready pre-count, play/pause control,
// round outcome tracking and display status flags, all on the 1 Hz game clock.
module game_phase_ctrl #(
  parameter int unsigned PRE_START = 3,
  parameter int unsigned ROUNDS_W  = 4
) (
  input  logic                one_hz_clk,
  input  logic                rst,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                end_game,
  input  logic                tower_complete,
  output logic                pause,
  output logic                timer_clear,
  output logic [1:0]          pre_count,
  output logic                playing,
  output logic                game_over,
  output logic                game_won,
  output logic                blink,
  output logic [ROUNDS_W-1:0] rounds,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_LOST   = 3'd4,
    S_WON    = 3'd5
  } state_t;

  localparam logic [1:0]          PRE_START_V = 2'(PRE_START);
  localparam logic [ROUNDS_W-1:0] ROUNDS_MAX  = '1;

  state_t              state_q, state_d;
  logic                start_prev_q, pause_prev_q;
  logic [1:0]          pre_count_q, pre_count_d;
  logic                timer_clear_q, timer_clear_d;
  logic                blink_q, blink_d;
  logic [ROUNDS_W-1:0] rounds_q, rounds_d;
  logic                start_rise, pause_rise;
  logic                flash_d;

  // Previous-value flops reset high so a button held through reset never counts as a press.
  assign start_rise = start_btn & ~start_prev_q;
  assign pause_rise = pause_btn & ~pause_prev_q;

  always_ff @(posedge one_hz_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_prev_q  <= 1'b1;
      pause_prev_q  <= 1'b1;
      pre_count_q   <= 2'd0;
      timer_clear_q <= 1'b0;
      blink_q       <= 1'b0;
      rounds_q      <= '0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_btn;
      pause_prev_q  <= pause_btn;
      pre_count_q   <= pre_count_d;
      timer_clear_q <= timer_clear_d;
      blink_q       <= blink_d;
      rounds_q      <= rounds_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pre_count_d   = pre_count_q;
    timer_clear_d = 1'b0;
    rounds_d      = rounds_q;
    blink_d       = 1'b0;
    flash_d       = 1'b0;

    case (state_q)
      S_IDLE, S_LOST, S_WON: begin
        if (start_rise) begin
          state_d       = S_READY;
          pre_count_d   = PRE_START_V;
          timer_clear_d = 1'b1;
          if (rounds_q != ROUNDS_MAX) rounds_d = rounds_q + ROUNDS_W'(1);
        end
      end
      S_READY: begin
        if (pre_count_q == 2'd1) begin
          state_d     = S_PLAY;
          pre_count_d = 2'd0;
        end else begin
          pre_count_d = pre_count_q - 2'd1;
        end
      end
      S_PLAY: begin
        // A completed tower outranks a simultaneous timer expiry.
        if (tower_complete)  state_d = S_WON;
        else if (end_game)   state_d = S_LOST;
        else if (pause_rise) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (tower_complete)  state_d = S_WON;
        else if (end_game)   state_d = S_LOST;
        else if (pause_rise) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    // Blink starts lit on entry to a flashing state, then toggles while it stays there.
    flash_d = (state_d == S_PAUSED) || (state_d == S_LOST) || (state_d == S_WON);
    if (flash_d) blink_d = (state_d == state_q) ? ~blink_q : 1'b1;
  end

  assign pause       = (state_q != S_PLAY);
  assign playing     = (state_q == S_PLAY);
  assign game_over   = (state_q == S_LOST);
  assign game_won    = (state_q == S_WON);
  assign timer_clear = timer_clear_q;
  assign pre_count   = pre_count_q;
  assign blink       = blink_q;
  assign rounds      = rounds_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed and randomized checks of game_phase_ctrl against a behavioural round model.
module tb_game_phase_ctrl;

  localparam int PRE = 3;
  localparam int RMAX = 15;

  logic       clk = 1'b0;
  logic       rst, start_btn, pause_btn, end_game, tower_complete;
  logic       pause, timer_clear, playing, game_over, game_won, blink;
  logic [1:0] pre_count;
  logic [3:0] rounds;
  logic [2:0] state_dbg;
  logic       d1_pause, d1_timer_clear, d1_playing, d1_game_over, d1_game_won, d1_blink;
  logic [1:0] d1_pre_count;
  logic [3:0] d1_rounds;
  logic [2:0] d1_state_dbg;

  int total = 0;
  int bad = 0;

  // Behavioural model: round phase held as flags plus a remaining get-ready count.
  int m_ready_left, m_rounds;
  bit m_play, m_paused, m_lost, m_won, m_blink, m_clear;
  bit m_prev_start, m_prev_pause;

  game_phase_ctrl #(.PRE_START(3), .ROUNDS_W(4)) dut (
    .one_hz_clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .end_game(end_game), .tower_complete(tower_complete), .pause(pause),
    .timer_clear(timer_clear), .pre_count(pre_count), .playing(playing),
    .game_over(game_over), .game_won(game_won), .blink(blink), .rounds(rounds),
    .state_dbg(state_dbg)
  );

  game_phase_ctrl #(.PRE_START(1), .ROUNDS_W(4)) dut1 (
    .one_hz_clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .end_game(end_game), .tower_complete(tower_complete), .pause(d1_pause),
    .timer_clear(d1_timer_clear), .pre_count(d1_pre_count), .playing(d1_playing),
    .game_over(d1_game_over), .game_won(d1_game_won), .blink(d1_blink),
    .rounds(d1_rounds), .state_dbg(d1_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ready_left = 0; m_rounds = 0;
    m_play = 0; m_paused = 0; m_lost = 0; m_won = 0; m_blink = 0; m_clear = 0;
    m_prev_start = 1; m_prev_pause = 1;
  endfunction

  function automatic void model_step();
    bit s_rise, p_rise, o_paused, o_lost, o_won, same;
    s_rise = start_btn && !m_prev_start;
    p_rise = pause_btn && !m_prev_pause;
    o_paused = m_paused; o_lost = m_lost; o_won = m_won;
    m_clear = 0;
    if (m_ready_left > 0) begin
      m_ready_left--;
      if (m_ready_left == 0) m_play = 1;
    end else if (m_play || m_paused) begin
      if (tower_complete) begin m_won = 1; m_play = 0; m_paused = 0; end
      else if (end_game) begin m_lost = 1; m_play = 0; m_paused = 0; end
      else if (p_rise) begin m_play = !m_play; m_paused = !m_paused; end
    end else if (s_rise) begin
      m_lost = 0; m_won = 0;
      m_ready_left = PRE;
      m_clear = 1;
      if (m_rounds < RMAX) m_rounds++;
    end
    same = (o_paused == m_paused) && (o_lost == m_lost) && (o_won == m_won);
    if (m_paused || m_lost || m_won) m_blink = same ? !m_blink : 1'b1;
    else m_blink = 0;
    m_prev_start = start_btn;
    m_prev_pause = pause_btn;
  endfunction

  task automatic check_all();
    chk("pause", 8'(pause), 8'(!m_play));
    chk("timer_clear", 8'(timer_clear), 8'(m_clear));
    chk("pre_count", 8'(pre_count), 8'(m_ready_left));
    chk("playing", 8'(playing), 8'(m_play));
    chk("game_over", 8'(game_over), 8'(m_lost));
    chk("game_won", 8'(game_won), 8'(m_won));
    chk("blink", 8'(blink), 8'(m_blink));
    chk("rounds", 8'(rounds), 8'(m_rounds));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic press_start();
    start_btn = 1; tick(); start_btn = 0;
  endtask

  initial begin
    start_btn = 1; pause_btn = 0; end_game = 0; tower_complete = 0;
    rst = 1;
    model_reset();
    #1;
    check_all();
    chk("rst_pause", 8'(pause), 8'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Start held through reset: no round may begin.
    repeat (3) tick();
    chk("held_pre_count", 8'(pre_count), 8'd0);
    chk("held_rounds", 8'(rounds), 8'd0);
    start_btn = 0; tick();

    press_start();
    chk("ready_pc3", 8'(pre_count), 8'd3);
    chk("ready_clear", 8'(timer_clear), 8'd1);
    chk("ready_rounds", 8'(rounds), 8'd1);
    chk("pre1_pc", 8'(d1_pre_count), 8'd1);
    chk("pre1_clear", 8'(d1_timer_clear), 8'd1);
    pause_btn = 1; tick(); pause_btn = 0;
    chk("ready_pc2", 8'(pre_count), 8'd2);
    chk("clear_one_cycle", 8'(timer_clear), 8'd0);
    chk("pre1_playing", 8'(d1_playing), 8'd1);
    tick();
    chk("ready_pc1", 8'(pre_count), 8'd1);
    tick();
    chk("play_entry", 8'(playing), 8'd1);
    chk("play_pause_low", 8'(pause), 8'd0);

    press_start();
    chk("start_in_play", 8'(playing), 8'd1);

    pause_btn = 1; tick(); pause_btn = 0;
    chk("paused_blink1", 8'(blink), 8'd1);
    tick(); chk("paused_blink0", 8'(blink), 8'd0);
    tick(); chk("paused_blink1b", 8'(blink), 8'd1);
    pause_btn = 1; tick(); pause_btn = 0;
    chk("resume_pause", 8'(pause), 8'd0);
    chk("resume_blink", 8'(blink), 8'd0);

    end_game = 1; tick(); end_game = 0;
    chk("lost_over", 8'(game_over), 8'd1);
    chk("lost_pause", 8'(pause), 8'd1);
    tick();
    press_start();
    chk("round2_clear", 8'(timer_clear), 8'd1);
    chk("round2_rounds", 8'(rounds), 8'd2);
    repeat (3) tick();
    tower_complete = 1; end_game = 1; tick(); tower_complete = 0; end_game = 0;
    chk("won_flag", 8'(game_won), 8'd1);
    chk("won_not_lost", 8'(game_over), 8'd0);
    repeat (3) tick();

    // Randomized play against the model.
    for (int i = 0; i < 300; i++) begin
      start_btn      = ($urandom_range(0, 5) == 0);
      pause_btn      = ($urandom_range(0, 4) == 0);
      end_game       = ($urandom_range(0, 14) == 0);
      tower_complete = ($urandom_range(0, 19) == 0);
      tick();
    end
    start_btn = 0; pause_btn = 0; end_game = 0; tower_complete = 0;

    // Enough rounds to saturate the counter.
    for (int r = 0; r < 18; r++) begin
      tick();
      press_start();
      repeat (4) tick();
      end_game = 1; tick(); end_game = 0;
    end
    chk("rounds_sat", 8'(rounds), 8'd15);

    tick();
    press_start();
    repeat (3) tick();
    pause_btn = 1; tick(); pause_btn = 0;
    chk("pre_reset_paused", 8'(pause), 8'd1);
    chk("pre_reset_blink", 8'(blink), 8'd1);

    // Asynchronous reset mid-cycle while paused.
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("async_rounds", 8'(rounds), 8'd0);
    chk("async_blink", 8'(blink), 8'd0);
    @(posedge clk);
    #1;
    rst = 0;
    tick();
    press_start();
    chk("post_reset_rounds", 8'(rounds), 8'd1);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
- Round-level sequencer for Sky-Stacker, running on the 1 Hz game clock directly upstream of the countdown timer.
- Generates the timer's pause control and a one-cycle timer-clear pulse.
- Runs a get-ready pre-count and tracks round outcome from the timer's end_game and the stacking logic's tower_complete.
- Drives status flags for the display path.

Parameters:
- PRE_START, 3, first get-ready digit shown before play begins (legal range 1..3).
- ROUNDS_W, 4, width of the saturating rounds-played counter.

Ports:
- one_hz_clk  in  1  game clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_btn  in  1  debounced start level; a press must span at least one one_hz_clk rising edge.
- pause_btn  in  1  debounced pause level; same press-width rule as start_btn.
- end_game  in  1  timer expired (level, from the countdown timer).
- tower_complete  in  1  stack reached the top (level, from the stacking logic).
- pause  out  1  freeze request to the countdown timer.
- timer_clear  out  1  one-cycle pulse; ORed with rst at the timer's reset input.
- pre_count  out  2  get-ready digit; 0 outside READY.
- playing  out  1  high in PLAY only.
- game_over  out  1  high in LOST.
- game_won  out  1  high in WON.
- blink  out  1  display flash.
- rounds  out  ROUNDS_W  rounds started; saturating.

Behaviour:
- Edge detection:
  - start_btn and pause_btn are each registered once per clock; a rise means current=1 and previous=0.
  - The previous-value registers reset to 1, so a button held through reset produces no rise until it is released and pressed again.
- State register with six states: IDLE, READY, PLAY, PAUSED, LOST, WON. Reset state is IDLE.
- Reset values: pause=1, timer_clear=0, pre_count=0, playing=0, game_over=0, game_won=0, blink=0, rounds=0.
- IDLE:
  - start rise -> READY; pre_count loads PRE_START; timer_clear=1 for that one cycle; rounds increments.
  - All other inputs are ignored.
- READY:
  - pre_count decrements by 1 each clock.
  - When pre_count==1 at a clock edge: -> PLAY and pre_count=0.
  - pause and start rises are ignored. end_game and tower_complete are ignored, since the timer was just cleared.
- PLAY: evaluated each edge in this priority order:
  - tower_complete=1 -> WON. If end_game rises on the same edge, WON still takes priority.
  - end_game=1 -> LOST.
  - pause rise -> PAUSED.
  - Otherwise stay in PLAY.
- PAUSED:
  - tower_complete -> WON; else end_game -> LOST; else pause rise -> PLAY.
  - start rise is ignored.
- LOST and WON:
  - Hold until start rise, then -> READY with the same actions as from IDLE (timer_clear pulse, pre_count load, rounds increment).
  - pause rise is ignored.
- Output decode:
  - pause = 1 in every state except PLAY. It is a decode of the registered state, so the timer first counts on the second edge after entering PLAY.
  - playing, game_over and game_won are state decodes.
- blink:
  - Toggles on every edge while in PAUSED, LOST or WON.
  - Forced to 0 in every other state.
  - Loads 1 on the edge that enters PAUSED, LOST or WON.
- rounds saturates at 2^ROUNDS_W-1 and does not wrap.
- timer_clear is registered: high exactly one cycle, aligned with the first READY cycle.
- Reset mid-round: asserting rst in any state asynchronously returns to IDLE with the reset values above. The timer is reset by the same rst.
- PRE_START=1: READY lasts exactly one cycle.

Test Plan:
- Reset with start_btn held high, then release and press again -> no transition while held; after re-press: READY, pre_count 3,2,1 on successive cycles, then PLAY, timer_clear high one cycle, rounds=1.
- In PLAY, press pause, wait 3 cycles, press pause again -> pause=1 and blink toggling 1,0,1 during PAUSED; back to PLAY with pause=0 and blink=0.
- In PLAY, raise end_game -> LOST next edge, game_over=1, pause=1; then start press -> READY, timer_clear pulse, rounds=2.
- In PLAY, raise tower_complete and end_game on the same edge -> WON, game_won=1, game_over=0.
- Press pause during READY, and press start during PLAY -> both ignored; pre_count sequence and state unchanged.
- Start 16 rounds with ROUNDS_W=4 -> rounds holds at 15; assert rst while in PAUSED -> all outputs at reset values immediately, without waiting for a clock edge.
